spi_mem_scheduler: RTL and testbench

Two-port scheduler that shares the SPI memory wrapper between two on-chip requesters. It grants one byte-wide read or write request at a time, round-robin, and turns each request into the wrapper's SPI frame sequence: address frame, gap, data frame, and for reads the MISO capture. It returns an ack pulse, a done pulse and read data. The block drives the wrapper's `SS_n` and `MOSI` and samples its `MISO`, all on the shared system clock.

---
 rtl/spi_mem_pkg.sv | 30 +++
 rtl/spi_frame_shifter.sv | 73 +++++++
 rtl/spi_mem_scheduler.sv | 215 +++++++++++++++++++++
 tb/tb_spi_mem_scheduler.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_mem_pkg.sv
// Shared constants, state encoding and helpers for the
// SPI memory scheduler and its frame shifter.
package spi_mem_pkg;

  localparam int FRAME_LEN = 10;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_GAP,
    ST_DATA,
    ST_RWAIT,
    ST_RECV,
    ST_FINISH
  } state_t;

  // cmd[1] is the read flag, cmd[0] the data-frame flag.
  function automatic logic [1:0] cmd_of(
    input logic is_data,
    input logic is_wr
  );
    return {~is_wr, is_data};
  endfunction

endpackage

// File: rtl/spi_frame_shifter.sv
// Shifts one cmd+payload frame out on MOSI, MSB first, and for
// read-data frames captures W MISO bits after MISO_DLY cycles.
module spi_frame_shifter
  import spi_mem_pkg::*;
#(
  parameter int W        = 8,
  parameter int MISO_DLY = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         rd,
  input  logic [1:0]   cmd,
  input  logic [W-1:0] payload,
  input  logic         miso,
  output logic         mosi,
  output logic         ss_n,
  output logic         tx_last,
  output logic         wait_last,
  output logic         frame_done,
  output logic [W-1:0] rx_data
);

  localparam int RX_FIRST = FRAME_LEN - 1 + MISO_DLY;
  localparam int RD_LEN   = RX_FIRST + W;
  localparam int CW       = $clog2(RD_LEN + 1);

  logic                 active;
  logic                 rd_q;
  logic [CW-1:0]        cnt;
  logic [FRAME_LEN-1:0] sreg;
  logic [W-1:0]         rx_q;
  logic [CW-1:0]        last_cnt;

  assign last_cnt = rd_q ? CW'(RD_LEN - 1)
                         : CW'(FRAME_LEN - 1);

  assign tx_last    = active & (cnt == CW'(FRAME_LEN - 1));
  assign wait_last  = active & rd_q
                    & (cnt == CW'(RX_FIRST - 1));
  assign frame_done = active & (cnt == last_cnt);

  // Last sample is folded in so the word is complete at frame_done.
  assign rx_data = {rx_q[W-2:0], miso};
  assign mosi    = sreg[FRAME_LEN-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      rd_q   <= 1'b0;
      ss_n   <= 1'b1;
      cnt    <= '0;
      sreg   <= '0;
      rx_q   <= '0;
    end else if (start) begin
      active <= 1'b1;
      rd_q   <= rd;
      ss_n   <= 1'b0;
      cnt    <= '0;
      sreg   <= {cmd, payload};
    end else if (active) begin
      cnt  <= cnt + 1'b1;
      sreg <= {sreg[FRAME_LEN-2:0], 1'b0};
      if (rd_q && cnt >= CW'(RX_FIRST))
        rx_q <= {rx_q[W-2:0], miso};
      if (frame_done) begin
        active <= 1'b0;
        ss_n   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_mem_scheduler.sv
// Round-robin two-port scheduler in front of the SPI memory
// wrapper, with per-direction address caches to skip frames.
module spi_mem_scheduler
  import spi_mem_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int GAP_CYC  = 1,
  parameter int MISO_DLY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        ack,
  output logic [1:0]        done,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);

  state_t state, state_d;

  logic [7:0]        gap_cnt;
  logic              gap_done;
  logic              last_gnt;

  logic              cur_port;
  logic              cur_we;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;

  logic [ADDR_W-1:0] wr_cache;
  logic [ADDR_W-1:0] rd_cache;
  logic              wr_valid;
  logic              rd_valid;

  logic              can_grant;
  logic              gnt_valid;
  logic              gnt_port;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_hit;

  logic              sh_start;
  logic              sh_rd;
  logic [1:0]        sh_cmd;
  logic [DATA_W-1:0] sh_payload;
  logic              tx_last;
  logic              wait_last;
  logic              frame_done;
  logic [DATA_W-1:0] rx_data;

  logic              done_enter;
  logic              rd_done;
  logic [1:0]        ack_d;
  logic [1:0]        done_d;
  logic              busy_d;

  assign gap_done = (gap_cnt == 8'(GAP_CYC - 1));

  // The last gap cycle after done doubles as an IDLE decision slot.
  always_comb begin
    can_grant = (state == ST_IDLE)
              | ((state == ST_FINISH) & gap_done);
    gnt_valid = can_grant & (|req);
    gnt_port  = (&req) ? ~last_gnt : req[1];
    sel_we    = gnt_port ? we[1] : we[0];
    sel_addr  = gnt_port ? addr1 : addr0;
    sel_wdata = gnt_port ? wdata1 : wdata0;
    sel_hit   = sel_we ? (wr_valid & (wr_cache == sel_addr))
                       : (rd_valid & (rd_cache == sel_addr));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE, ST_FINISH: begin
        if (gnt_valid)
          state_d = sel_hit ? ST_DATA : ST_ADDR;
        else if (state == ST_IDLE || gap_done)
          state_d = ST_IDLE;
      end
      ST_ADDR:  if (tx_last) state_d = ST_GAP;
      ST_GAP:   if (gap_done) state_d = ST_DATA;
      ST_DATA: begin
        if (tx_last) begin
          if (cur_we)            state_d = ST_FINISH;
          else if (MISO_DLY > 1) state_d = ST_RWAIT;
          else                   state_d = ST_RECV;
        end
      end
      ST_RWAIT: if (wait_last) state_d = ST_RECV;
      ST_RECV:  if (frame_done) state_d = ST_FINISH;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sh_start   = 1'b0;
    sh_rd      = 1'b0;
    sh_cmd     = CMD_WR_ADDR;
    sh_payload = '0;
    unique case (1'b1)
      gnt_valid & ~sel_hit: begin
        sh_start   = 1'b1;
        sh_cmd     = cmd_of(1'b0, sel_we);
        sh_payload = sel_addr;
      end
      gnt_valid & sel_hit: begin
        sh_start   = 1'b1;
        sh_rd      = ~sel_we;
        sh_cmd     = cmd_of(1'b1, sel_we);
        sh_payload = sel_we ? sel_wdata : '0;
      end
      (state == ST_GAP) & gap_done: begin
        sh_start   = 1'b1;
        sh_rd      = ~cur_we;
        sh_cmd     = cmd_of(1'b1, cur_we);
        sh_payload = cur_we ? cur_wdata : '0;
      end
      default: ;
    endcase

    done_enter = (state_d == ST_FINISH)
               & (state != ST_FINISH);
    rd_done    = done_enter & ~cur_we;
    ack_d      = {gnt_port, ~gnt_port} & {2{gnt_valid}};
    done_d     = {cur_port, ~cur_port} & {2{done_enter}};
    busy_d     = ((state_d != ST_IDLE)
               & (state_d != ST_FINISH)) | done_enter;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack   <= '0;
      done  <= '0;
      busy  <= 1'b0;
      rdata <= '0;
    end else begin
      ack  <= ack_d;
      done <= done_d;
      busy <= busy_d;
      if (rd_done) rdata <= rx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt  <= 1'b1;
      cur_port  <= 1'b0;
      cur_we    <= 1'b0;
      cur_addr  <= '0;
      cur_wdata <= '0;
      wr_cache  <= '0;
      rd_cache  <= '0;
      wr_valid  <= 1'b0;
      rd_valid  <= 1'b0;
      gap_cnt   <= '0;
    end else begin
      if (gnt_valid) begin
        last_gnt  <= gnt_port;
        cur_port  <= gnt_port;
        cur_we    <= sel_we;
        cur_addr  <= sel_addr;
        cur_wdata <= sel_wdata;
      end
      if (state == ST_ADDR && tx_last) begin
        if (cur_we) begin
          wr_cache <= cur_addr;
          wr_valid <= 1'b1;
        end else begin
          rd_cache <= cur_addr;
          rd_valid <= 1'b1;
        end
      end
      if (state_d != state)
        gap_cnt <= '0;
      else if (state == ST_GAP || state == ST_FINISH)
        gap_cnt <= gap_cnt + 1'b1;
    end
  end

  spi_frame_shifter #(
    .W        (DATA_W),
    .MISO_DLY (MISO_DLY)
  ) u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (sh_start),
    .rd         (sh_rd),
    .cmd        (sh_cmd),
    .payload    (sh_payload),
    .miso       (MISO),
    .mosi       (MOSI),
    .ss_n       (SS_n),
    .tx_last    (tx_last),
    .wait_last  (wait_last),
    .frame_done (frame_done),
    .rx_data    (rx_data)
  );

endmodule

// File: tb/tb_spi_mem_scheduler.sv
// Directed bench for spi_mem_scheduler with a behavioural
// SPI memory wrapper that records every completed frame.
module tb_spi_mem_scheduler;

  localparam int MD = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req, we;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic [1:0] ack, done;
  logic [7:0] rdata;
  logic       busy, SS_n, MOSI, MISO;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_mem_scheduler #(
    .ADDR_W(8), .DATA_W(8), .GAP_CYC(1), .MISO_DLY(MD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack(ack), .done(done), .rdata(rdata), .busy(busy),
    .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
  );

  // Wrapper model: sampled mid-cycle, MISO updated mid-cycle.
  logic [9:0] frames[$];
  logic [7:0] smem[256];
  logic [7:0] swa, sra, sval;
  logic [9:0] sbits;
  logic       srd;
  logic       miso_r;
  int         sn;

  assign MISO = miso_r;

  initial begin
    for (int i = 0; i < 256; i++) smem[i] = 8'h00;
    sn = 0; srd = 0; miso_r = 0; sbits = 0;
    swa = 0; sra = 0; sval = 0;
    forever begin
      @(negedge clk);
      if (SS_n !== 1'b0) begin
        sn = 0; srd = 0; miso_r = 0;
      end else begin
        sbits = {sbits[8:0], MOSI};
        sn++;
        if (sn == 10) begin
          frames.push_back(sbits);
          case (sbits[9:8])
            2'b00: swa = sbits[7:0];
            2'b01: smem[swa] = sbits[7:0];
            2'b10: sra = sbits[7:0];
            default: begin sval = smem[sra]; srd = 1; end
          endcase
        end
        if (srd && sn - 1 >= 9 + MD && sn - 1 <= 16 + MD)
          miso_r = sval[7 - (sn - 1 - 9 - MD)];
        else
          miso_r = 0;
      end
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic run_txn(
    input int p, input logic w,
    input logic [7:0] a, input logic [7:0] d,
    output int ack_c, output int done_c,
    output int busy_c, output logic [7:0] rd
  );
    @(posedge clk); #1;
    frames.delete();
    we[p] = w;
    if (p == 0) begin addr0 = a; wdata0 = d; end
    else        begin addr1 = a; wdata1 = d; end
    req[p] = 1'b1;
    ack_c = -1; done_c = -1; busy_c = 0; rd = 0;
    for (int k = 1; k <= 200 && done_c < 0; k++) begin
      @(posedge clk); #1;
      if (busy) busy_c++;
      if (ack[p] && ack_c < 0) begin
        ack_c = k; req[p] = 1'b0;
      end
      if (done[p]) begin done_c = k; rd = rdata; end
    end
    req[p] = 1'b0;
    if (done_c < 0) begin
      checks++; errors++;
      $display("FAIL txn_timeout: got none want done");
    end
  endtask

  typedef struct {
    int         port;
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
    int         exp_done;
    logic [7:0] exp_rd;
    int         nfr;
    logic [9:0] f0;
    logic [9:0] f1;
  } vec_t;

  vec_t vecs[7];

  int         ac, dc, bc;
  logic [7:0] rv;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int gnt[3];
    int ng, nd, d1, fall, ack2, p0left, n22, n30, mism;
    logic prev_ss;
    logic [7:0] ed;

    vecs[0] = '{0, 1'b1, 8'd100, 8'd11, 22, 8'h00, 2, 10'h064, 10'h10B};
    vecs[1] = '{0, 1'b1, 8'd100, 8'd22, 11, 8'h00, 1, 10'h116, 10'h000};
    vecs[2] = '{1, 1'b0, 8'd100, 8'd0,  30, 8'd22, 2, 10'h264, 10'h300};
    vecs[3] = '{1, 1'b1, 8'd50,  8'hA5, 22, 8'd22, 2, 10'h032, 10'h1A5};
    vecs[4] = '{0, 1'b0, 8'd50,  8'd0,  30, 8'hA5, 2, 10'h232, 10'h300};
    vecs[5] = '{1, 1'b0, 8'd50,  8'd0,  19, 8'hA5, 1, 10'h300, 10'h000};
    vecs[6] = '{1, 1'b1, 8'd50,  8'h3C, 11, 8'hA5, 1, 10'h13C, 10'h000};

    rst_n = 0; req = 0; we = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
    chk("rst_ss_n", SS_n, 1);
    chk("rst_mosi", MOSI, 0);
    chk("rst_ack", ack, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", rdata, 0);

    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i].port, vecs[i].w, vecs[i].a, vecs[i].d,
              ac, dc, bc, rv);
      chk($sformatf("v%0d_ack", i), ac, 1);
      chk($sformatf("v%0d_done", i), dc, vecs[i].exp_done);
      chk($sformatf("v%0d_busy", i), bc, vecs[i].exp_done);
      chk($sformatf("v%0d_rdata", i), rv, vecs[i].exp_rd);
      chk($sformatf("v%0d_nfr", i), frames.size(), vecs[i].nfr);
      chk($sformatf("v%0d_f0", i), frames[0], vecs[i].f0);
      if (vecs[i].nfr > 1)
        chk($sformatf("v%0d_f1", i), frames[1], vecs[i].f1);
    end

    // Simultaneous requests: port 0 re-requests right after its ack.
    @(posedge clk); #1;
    addr0 = 8'd10; wdata0 = 8'd1;
    addr1 = 8'd20; wdata1 = 8'd2;
    we = 2'b11; req = 2'b11;
    gnt = '{-1, -1, -1};
    ng = 0; nd = 0; d1 = -1; fall = -1; ack2 = -1;
    p0left = 2; prev_ss = 1;
    for (int k = 1; k <= 300 && nd < 3; k++) begin
      @(posedge clk); #1;
      if (d1 >= 0 && fall < 0 && prev_ss && !SS_n) fall = k;
      prev_ss = SS_n;
      if (ack != 2'b00) begin
        if (ng < 3) gnt[ng] = int'(ack[1]);
        if (ng == 1) ack2 = k;
        ng++;
        if (ack[0]) begin
          p0left--;
          if (p0left == 0) req[0] = 0;
          else wdata0 = 8'd3;
        end
        if (ack[1]) req[1] = 0;
      end
      if (done != 2'b00) begin
        if (nd == 0) d1 = k;
        nd++;
      end
    end
    req = 0;
    chk("rr_ndone", nd, 3);
    chk("rr_gnt0", gnt[0], 0);
    chk("rr_gnt1", gnt[1], 1);
    chk("rr_gnt2", gnt[2], 0);
    chk("rr_gap", fall - d1, 1);
    chk("rr_ack_at_frame", ack2, fall);

    // Sequential fill and read-back.
    n22 = 0; n30 = 0; mism = 0;
    for (int i = 0; i < 100; i++) begin
      ed = 8'(11 * ((i % 23) + 1));
      run_txn(i % 2, 1'b1, 8'(100 + i), ed, ac, dc, bc, rv);
      if (dc == 22) n22++;
    end
    for (int i = 0; i < 100; i++) begin
      ed = 8'(11 * ((i % 23) + 1));
      run_txn((i + 1) % 2, 1'b0, 8'(100 + i), 8'd0,
              ac, dc, bc, rv);
      if (dc == 30) n30++;
      if (rv !== ed) mism++;
    end
    chk("fill_wr_lat", n22, 100);
    chk("fill_rd_lat", n30, 100);
    chk("fill_mismatch", mism, 0);

    // Reset during a cache-hit data frame.
    run_txn(0, 1'b1, 8'd77, 8'h5A, ac, dc, bc, rv);
    chk("pre_rst_done", dc, 22);
    @(posedge clk); #1;
    addr0 = 8'd77; wdata0 = 8'h5A; we[0] = 1; req[0] = 1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k == 1) chk("hit_ack", ack[0], 1);
      if (k == 4) chk("mid_frame_ss", SS_n, 0);
    end
    rst_n = 0; req = 0;
    #1;
    chk("async_ss_n", SS_n, 1);
    chk("async_busy", busy, 0);
    chk("async_mosi", MOSI, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    nd = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (done != 2'b00) nd++;
    end
    chk("abort_no_done", nd, 0);
    run_txn(0, 1'b1, 8'd77, 8'h5A, ac, dc, bc, rv);
    chk("post_rst_done", dc, 22);
    chk("post_rst_nfr", frames.size(), 2);
    chk("post_rst_f0", frames[0], 10'h04D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
